// File: rtl/microwave_cook_ctrl.sv
// Microwave cooking sequencer: keeps the mm:ss cook time from the divided tick,
// interprets keypad and door, and drives magnetron, lamp, buzzer and display.
module microwave_cook_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 10,
  parameter int unsigned QUICK_SECS    = 30,
  parameter int unsigned BEEP_SECS     = 3,
  parameter int unsigned MAX_MIN       = 99
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_clk,
  input  logic       btn_add_10s,
  input  logic       btn_add_min,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       door_open,
  output logic       magnetron_on,
  output logic       lamp_on,
  output logic       buzzer,
  output logic [6:0] min_o,
  output logic [5:0] sec_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [6:0]    MAX_M      = 7'(MAX_MIN);
  localparam logic [6:0]    QUICK_M    = 7'(QUICK_SECS / 60);
  localparam logic [5:0]    QUICK_S    = 6'(QUICK_SECS % 60);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_SECS - 1);

  state_t        state, state_n;
  logic [6:0]    min_n;
  logic [5:0]    sec_n;
  logic [PW-1:0] presc, presc_n;
  logic [BW-1:0] beep, beep_n;
  logic [12:0]   t_cur;

  logic tick_s1, tick_s2, tick_d;
  logic add10_d, addm_d, start_d, stop_d;
  logic tick, e_add10, e_addm, e_start, e_stop, e_any, time_zero;

  assign tick      = tick_s2 & ~tick_d;
  assign e_add10   = btn_add_10s & ~add10_d;
  assign e_addm    = btn_add_min & ~addm_d;
  assign e_start   = btn_start & ~start_d;
  assign e_stop    = btn_stop & ~stop_d;
  assign e_any     = e_add10 | e_addm | e_start | e_stop;
  assign time_zero = (min_o == '0) && (sec_o == '0);
  assign state_o   = state;

  // Time arithmetic on packed {minutes, seconds}
  function automatic logic [12:0] add10_f(input logic [12:0] t);
    logic [6:0] m;
    logic [5:0] s;
    m = t[12:6];
    s = t[5:0];
    if (s >= 6'd50) begin
      if (m >= MAX_M) return {MAX_M, 6'd59};
      return {m + 7'd1, s - 6'd50};
    end
    return {m, s + 6'd10};
  endfunction

  function automatic logic [12:0] addmin_f(input logic [12:0] t);
    if (t[12:6] >= MAX_M) return t;
    return {t[12:6] + 7'd1, t[5:0]};
  endfunction

  function automatic logic [12:0] dec_f(input logic [12:0] t);
    if (t[5:0] == 6'd0) return {t[12:6] - 7'd1, 6'd59};
    return {t[12:6], t[5:0] - 6'd1};
  endfunction

  always_comb begin
    state_n = state;
    presc_n = presc;
    beep_n  = beep;
    t_cur   = {min_o, sec_o};
    unique case (state)
      IDLE: begin
        if (e_stop) begin
          t_cur = '0;
        end else if (e_start) begin
          if (!door_open) begin
            state_n = COOK;
            t_cur   = {QUICK_M, QUICK_S};
            presc_n = '0;
          end
        end else if (e_addm) begin
          state_n = SET;
          t_cur   = addmin_f(t_cur);
        end else if (e_add10) begin
          state_n = SET;
          t_cur   = add10_f(t_cur);
        end
      end
      SET: begin
        if (e_stop) begin
          state_n = IDLE;
          t_cur   = '0;
        end else if (e_start) begin
          if (!door_open) begin
            state_n = COOK;
            presc_n = '0;
          end
        end else if (e_addm) begin
          t_cur = addmin_f(t_cur);
        end else if (e_add10) begin
          t_cur = add10_f(t_cur);
        end
      end
      COOK: begin
        // Pausing swallows a coincident tick; otherwise the tick and add_min compose
        if (door_open || e_stop) begin
          state_n = PAUSE;
        end else if (time_zero) begin
          state_n = DONE;
          presc_n = '0;
          beep_n  = '0;
        end else begin
          if (tick) begin
            if (presc == PRESC_LAST) begin
              presc_n = '0;
              t_cur   = dec_f(t_cur);
            end else begin
              presc_n = presc + PW'(1);
            end
          end
          if (e_addm) t_cur = addmin_f(t_cur);
        end
      end
      PAUSE: begin
        if (e_stop) begin
          state_n = IDLE;
          t_cur   = '0;
        end else if (e_start && !door_open) begin
          state_n = COOK;
        end
      end
      DONE: begin
        t_cur = '0;
        if (door_open || e_any) begin
          state_n = IDLE;
        end else if (tick) begin
          if (presc == PRESC_LAST) begin
            presc_n = '0;
            if (beep == BEEP_LAST) state_n = IDLE;
            else beep_n = beep + BW'(1);
          end else begin
            presc_n = presc + PW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        t_cur   = '0;
      end
    endcase
    {min_n, sec_n} = t_cur;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      min_o        <= '0;
      sec_o        <= '0;
      presc        <= '0;
      beep         <= '0;
      tick_s1      <= 1'b0;
      tick_s2      <= 1'b0;
      tick_d       <= 1'b0;
      add10_d      <= 1'b0;
      addm_d       <= 1'b0;
      start_d      <= 1'b0;
      stop_d       <= 1'b0;
      magnetron_on <= 1'b0;
      lamp_on      <= 1'b0;
      buzzer       <= 1'b0;
    end else begin
      state        <= state_n;
      min_o        <= min_n;
      sec_o        <= sec_n;
      presc        <= presc_n;
      beep         <= beep_n;
      tick_s1      <= tick_clk;
      tick_s2      <= tick_s1;
      tick_d       <= tick_s2;
      add10_d      <= btn_add_10s;
      addm_d       <= btn_add_min;
      start_d      <= btn_start;
      stop_d       <= btn_stop;
      // Outputs follow the next state so the heater drops together with 00:00
      magnetron_on <= (state_n == COOK) && ({min_n, sec_n} != '0);
      lamp_on      <= (state_n == COOK) || door_open;
      buzzer       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Scoreboard bench for microwave_cook_ctrl: directed scenarios then random operations,
// checked against a total-seconds reference model.
module tb_microwave_cook_ctrl;

  localparam int TPS   = 2;
  localparam int BEEP  = 2;
  localparam int QUICK = 30;
  localparam int MAXT  = 99 * 60 + 59;
  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  logic       clock_in = 1'b0;
  logic       reset, tick_clk, btn_add_10s, btn_add_min, btn_start, btn_stop, door_open;
  logic       magnetron_on, lamp_on, buzzer;
  logic [6:0] min_o;
  logic [5:0] sec_o;
  logic [2:0] state_o;

  microwave_cook_ctrl #(
    .TICKS_PER_SEC(TPS),
    .QUICK_SECS(QUICK),
    .BEEP_SECS(BEEP),
    .MAX_MIN(99)
  ) dut (
    .clock_in(clock_in), .reset(reset), .tick_clk(tick_clk),
    .btn_add_10s(btn_add_10s), .btn_add_min(btn_add_min),
    .btn_start(btn_start), .btn_stop(btn_stop), .door_open(door_open),
    .magnetron_on(magnetron_on), .lamp_on(lamp_on), .buzzer(buzzer),
    .min_o(min_o), .sec_o(sec_o), .state_o(state_o)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    string tag;
    int    st;
    int    mn;
    int    sc;
    bit    mag;
    bit    lamp;
    bit    buz;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic sample = 1'b0;

  // Reference model state: total seconds rather than mm:ss registers
  int m_state, m_t, m_pc, m_beep;
  bit m_door;

  task automatic check(input exp_t e);
    checks++;
    if (state_o !== 3'(e.st) || min_o !== 7'(e.mn) || sec_o !== 6'(e.sc) ||
        magnetron_on !== e.mag || lamp_on !== e.lamp || buzzer !== e.buz) begin
      errors++;
      $display("FAIL %s: got st=%0d %0d:%0d mag=%0b lamp=%0b buz=%0b, expected st=%0d %0d:%0d mag=%0b lamp=%0b buz=%0b",
               e.tag, state_o, min_o, sec_o, magnetron_on, lamp_on, buzzer,
               e.st, e.mn, e.sc, e.mag, e.lamp, e.buz);
    end
  endtask

  always @(negedge clock_in) begin
    if (sample) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
        check(q.pop_front());
      end
    end
  end

  function automatic exp_t model_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.st   = m_state;
    e.mn   = m_t / 60;
    e.sc   = m_t % 60;
    e.mag  = (m_state == S_COOK) && (m_t > 0);
    e.lamp = (m_state == S_COOK) || m_door;
    e.buz  = (m_state == S_DONE);
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic expect_now(input string tag);
    q.push_back(model_exp(tag));
    sample = 1'b1;
    step(1);
    sample = 1'b0;
  endtask

  function automatic void m_add10();
    m_t = (m_t + 10 > MAXT) ? MAXT : m_t + 10;
  endfunction

  function automatic void m_addmin();
    if (m_t / 60 < 99) m_t += 60;
  endfunction

  function automatic void m_reset();
    m_state = S_IDLE; m_t = 0; m_pc = 0; m_beep = 0;
  endfunction

  // b: 0=add_10s 1=add_min 2=start 3=stop
  task automatic press(input int b, input string tag);
    case (b)
      0: btn_add_10s = 1'b1;
      1: btn_add_min = 1'b1;
      2: btn_start   = 1'b1;
      default: btn_stop = 1'b1;
    endcase
    step(2);
    btn_add_10s = 1'b0; btn_add_min = 1'b0; btn_start = 1'b0; btn_stop = 1'b0;
    step(2);
    case (m_state)
      S_IDLE:
        if (b == 2 && !m_door) begin m_state = S_COOK; m_t = QUICK; m_pc = 0; end
        else if (b == 1) begin m_addmin(); m_state = S_SET; end
        else if (b == 0) begin m_add10(); m_state = S_SET; end
      S_SET:
        if (b == 3) begin m_state = S_IDLE; m_t = 0; end
        else if (b == 2) begin if (!m_door) begin m_state = S_COOK; m_pc = 0; end end
        else if (b == 1) m_addmin();
        else m_add10();
      S_COOK:
        if (b == 3) m_state = S_PAUSE;
        else if (b == 1) m_addmin();
      S_PAUSE:
        if (b == 3) begin m_state = S_IDLE; m_t = 0; end
        else if (b == 2 && !m_door) m_state = S_COOK;
      default: begin m_state = S_IDLE; m_t = 0; end
    endcase
    expect_now(tag);
  endtask

  task automatic tick(input string tag);
    tick_clk = 1'b1;
    step(4);
    tick_clk = 1'b0;
    step(2);
    if (m_state == S_COOK) begin
      m_pc++;
      if (m_pc == TPS) begin
        m_pc = 0;
        m_t--;
        if (m_t == 0) begin m_state = S_DONE; m_beep = 0; end
      end
    end else if (m_state == S_DONE) begin
      m_pc++;
      if (m_pc == TPS) begin
        m_pc = 0;
        m_beep++;
        if (m_beep == BEEP) m_state = S_IDLE;
      end
    end
    expect_now(tag);
  endtask

  task automatic door(input bit v, input string tag);
    door_open = v;
    step(3);
    m_door = v;
    if (v && m_state == S_COOK) m_state = S_PAUSE;
    if (v && m_state == S_DONE) m_state = S_IDLE;
    expect_now(tag);
  endtask

  initial begin
    reset = 1'b1; tick_clk = 1'b0; door_open = 1'b0;
    btn_add_10s = 1'b0; btn_add_min = 1'b0; btn_start = 1'b0; btn_stop = 1'b0;
    m_door = 1'b0;
    m_reset();
    step(3);
    reset = 1'b0;
    step(1);
    expect_now("reset_state");

    // Scenario 1: 3 x add_10s, start, 4 ticks
    for (int i = 0; i < 3; i++) press(0, "s1_add10");
    press(2, "s1_start");
    for (int i = 0; i < 4; i++) tick("s1_tick");
    press(3, "s1_stop_pause");
    press(3, "s1_stop_idle");

    // Scenario 2: 01:00 borrow, run to DONE, beep timeout
    press(1, "s2_addmin");
    press(2, "s2_start");
    tick("s2_tick");
    tick("s2_borrow");
    for (int i = 0; i < 200 && m_state == S_COOK; i++) tick("s2_run");
    for (int i = 0; i < 4; i++) tick("s2_beep");

    // Scenario 3: pause mid-second and resume
    press(0, "s3_add10"); press(0, "s3_add10");
    press(2, "s3_start");
    tick("s3_half");
    door(1'b1, "s3_door_open");
    tick("s3_tick_paused");
    door(1'b0, "s3_door_close");
    press(2, "s3_resume");
    tick("s3_resume_tick");
    press(3, "s3_stop"); press(3, "s3_stop");

    // Scenario 4: quick start, door-open start ignored, stop from PAUSE
    press(2, "s4_quick");
    press(3, "s4_pause");
    press(3, "s4_idle");
    press(0, "s4_set");
    door(1'b1, "s4_door");
    press(2, "s4_start_door_open");
    door(1'b0, "s4_door_close");
    press(2, "s4_start");
    press(3, "s4_pause2");
    press(3, "s4_idle2");

    // Scenario 5: saturation
    for (int i = 0; i < 100; i++) press(1, "s5_addmin");
    for (int i = 0; i < 6; i++) press(0, "s5_add10");
    press(0, "s5_add10_hold");
    press(1, "s5_addmin_hold");
    press(3, "s5_stop");

    // Scenario 6: asynchronous reset mid-cook
    press(2, "s6_start");
    tick("s6_tick");
    @(posedge clock_in);
    #3 reset = 1'b1;
    #1;
    m_reset();
    check(model_exp("s6_async_reset"));
    step(2);
    reset = 1'b0;
    step(1);
    expect_now("s6_after_reset");

    // Random operations
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        tick("rnd_tick");
      end else if (r < 8) begin
        int b;
        b = int'($urandom_range(0, 3));
        if (m_door && b != 2) door(1'b0, "rnd_door_close");
        else press(b, "rnd_press");
      end else begin
        door(~m_door, "rnd_door");
      end
    end

    step(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
